// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// uart_tx_arbiter : round-robin sharing of one UART transmitter among NUM_REQ
//                   byte requesters, with frame sequencing and a watchdog.
// Revision        : 1.0
// ============================================================================
module uart_tx_arbiter #(
   parameter int  NUM_REQ        = 4,
   parameter int  DATA_W         = 8,
   parameter int  GAP_CYCLES     = 16,
   parameter int  TIMEOUT_CYCLES = 20000,
   localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic [NUM_REQ-1:0]        err,
   output logic                      uart_start,
   output logic [DATA_W-1:0]         uart_txin,
   input  logic                      uart_txdone,
   output logic                      busy,
   output logic [IDX_W-1:0]          owner
);

   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      GAP   = 2'd3
   } state_t;

   state_t              state, state_nx;
   logic [IDX_W-1:0]    rr_ptr, rr_ptr_nx;
   logic [IDX_W-1:0]    owner_nx, winner, next_ptr;
   logic [WD_W-1:0]     wd_cnt, wd_cnt_nx;
   logic [GAP_W-1:0]    gap_cnt, gap_cnt_nx;
   logic [NUM_REQ-1:0]  gnt_nx, done_nx, err_nx;
   logic                start_nx, busy_nx;
   logic [DATA_W-1:0]   txin_nx, sel_data;

   // First asserted request at or after the pointer, searching upward with wrap.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
      logic [IDX_W-1:0] pick;
      logic [IDX_W-1:0] cand;
      logic             found;
      pick  = p;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(p) + k) % NUM_REQ);
         if (!found && r[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign winner   = rr_pick(req, rr_ptr);
   assign next_ptr = (owner == IDX_LAST) ? '0 : owner + 1'b1;

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) begin
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_nx   = state;
      rr_ptr_nx  = rr_ptr;
      owner_nx   = owner;
      txin_nx    = uart_txin;
      wd_cnt_nx  = wd_cnt;
      gap_cnt_nx = gap_cnt;
      gnt_nx     = '0;
      done_nx    = '0;
      err_nx     = '0;
      start_nx   = 1'b0;

      case (state)
         IDLE: begin
            if (|req) begin
               gnt_nx[winner] = 1'b1;
               txin_nx        = sel_data;
               owner_nx       = winner;
               state_nx       = START;
            end
         end
         START: begin
            start_nx  = 1'b1;
            wd_cnt_nx = '0;
            state_nx  = WAIT;
         end
         WAIT: begin
            // Completion takes priority over a watchdog expiry in the same cycle.
            if (uart_txdone) begin
               done_nx[owner] = 1'b1;
               rr_ptr_nx      = next_ptr;
               gap_cnt_nx     = '0;
               state_nx       = GAP;
            end else if (wd_cnt == WD_LAST) begin
               err_nx[owner] = 1'b1;
               rr_ptr_nx     = next_ptr;
               gap_cnt_nx    = '0;
               state_nx      = GAP;
            end else begin
               wd_cnt_nx = wd_cnt + 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nx = IDLE;
            end else begin
               gap_cnt_nx = gap_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      busy_nx = (state_nx != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         owner      <= '0;
         uart_txin  <= '0;
         wd_cnt     <= '0;
         gap_cnt    <= '0;
         gnt        <= '0;
         done       <= '0;
         err        <= '0;
         uart_start <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nx;
         rr_ptr     <= rr_ptr_nx;
         owner      <= owner_nx;
         uart_txin  <= txin_nx;
         wd_cnt     <= wd_cnt_nx;
         gap_cnt    <= gap_cnt_nx;
         gnt        <= gnt_nx;
         done       <= done_nx;
         err        <= err_nx;
         uart_start <= start_nx;
         busy       <= busy_nx;
      end
   end

endmodule

`default_nettype wire
